// File: rtl/mem_block_mover_pkg.sv
// Shared encodings for the block mover: FSM state codes and command modes.
package mem_block_mover_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_block_mover_ptr.sv
// Address pointer for the block mover: loadable register that steps by one,
// up or down, with silent modulo wrap.
module mem_ptr_step #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             step_i,
  input  logic             down_i,
  output logic [WIDTH-1:0] ptr_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (step_i) begin
      ptr_d = down_i ? (ptr_q - ONE) : (ptr_q + ONE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/mem_block_mover.sv
// Memory block copy/fill engine driving a single-port data memory.
//   state    | meaning
//   IDLE     | waiting for start; memory bus quiet
//   READ     | copy only: present src_ptr, capture word into data_q
//   WRITE    | present dst_ptr with data_q, memory write enabled
//   DONE     | one-cycle completion pulse
module mem_block_mover
  import mem_block_mover_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] src_i,
  input  logic [WIDTH-1:0] dst_i,
  input  logic [WIDTH-1:0] len_i,
  input  logic [WIDTH-1:0] pattern_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             mem_en_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic [WIDTH-1:0] mem_rdata_i
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;

  logic             start_ok;
  logic [WIDTH-1:0] diff, len_m1, src_load, dst_load;
  logic             backward;
  logic [WIDTH-1:0] src_ptr, dst_ptr;

  assign start_ok = (state_q == ST_IDLE) && start_i;

  // Destination overlapping ahead of the source must be copied from the top down.
  assign diff     = dst_i - src_i;
  assign backward = (mode_i == MODE_COPY) && (diff != '0) && (diff < len_i);
  assign len_m1   = len_i - ONE;
  assign src_load = backward ? (src_i + len_m1) : src_i;
  assign dst_load = backward ? (dst_i + len_m1) : dst_i;

  mem_ptr_step #(.WIDTH(WIDTH)) u_src_ptr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (start_ok),
    .load_val_i (src_load),
    .step_i     (state_q == ST_READ),
    .down_i     (dir_q),
    .ptr_o      (src_ptr)
  );

  mem_ptr_step #(.WIDTH(WIDTH)) u_dst_ptr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (start_ok),
    .load_val_i (dst_load),
    .step_i     (state_q == ST_WRITE),
    .down_i     (dir_q),
    .ptr_o      (dst_ptr)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      data_q      <= '0;
      mode_q      <= MODE_COPY;
      dir_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    mode_d      = mode_q;
    dir_d       = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          remaining_d = len_i;
          mode_d      = mode_i;
          dir_d       = backward;
          data_d      = pattern_i;
          if (len_i == '0) begin
            state_d = ST_DONE;
          end else if (mode_i == MODE_FILL) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        data_d  = mem_rdata_i;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        remaining_d = remaining_q - ONE;
        if (remaining_q == ONE) begin
          state_d = ST_DONE;
        end else if (mode_q == MODE_COPY) begin
          state_d = ST_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write enable is gated by reset so an interrupted WRITE never commits.
  always_comb begin
    busy_o      = (state_q == ST_READ) || (state_q == ST_WRITE);
    done_o      = (state_q == ST_DONE);
    mem_en_o    = (state_q == ST_WRITE) && !rst_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (state_q == ST_READ) begin
      mem_addr_o = src_ptr;
    end else if (state_q == ST_WRITE) begin
      mem_addr_o  = dst_ptr;
      mem_wdata_o = data_q;
    end
  end

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed bench for mem_block_mover with a behavioural data memory and a
// write-transaction scoreboard.
module tb_mem_block_mover;

  logic       clk = 1'b0;
  logic       rst, start, mode;
  logic [7:0] src, dst, len, pattern;
  logic       busy, done, mem_en;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [0:255];
  logic       bd_we;
  logic [7:0] bd_addr, bd_data;

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int en_mark = 0;
  logic [7:0] first_wr = 8'h00;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  mem_block_mover #(.WIDTH(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .mode_i      (mode),
    .src_i       (src),
    .dst_i       (dst),
    .len_i       (len),
    .pattern_i   (pattern),
    .busy_o      (busy),
    .done_o      (done),
    .mem_en_o    (mem_en),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) mem[mem_addr] <= mem_wdata;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) chk("busy_done_excl", {31'b0, busy & done}, 32'd0);
    if (mem_en) begin
      if (en_cnt == en_mark) first_wr = mem_addr;
      en_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {16'h0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
      end else begin
        chk("sb_write", {16'h0, mem_addr, mem_wdata}, {16'h0, exp_q.pop_front()});
      end
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Expected writes follow memmove semantics in the order the direction rule implies.
  task automatic start_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] l, input logic [7:0] p, input int max_push);
    logic [7:0] diff, a, k;
    logic back;
    diff = d - s;
    back = (m == 1'b0) && (diff != 8'h00) && (diff < l);
    for (int i = 0; i < int'(l); i++) begin
      k = back ? 8'(int'(l) - 1 - i) : 8'(i);
      a = d + k;
      if (i < max_push) exp_q.push_back({a, (m ? p : mem[8'(s + k)])});
    end
    en_mark = en_cnt;
    mode = m; src = s; dst = d; len = l; pattern = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_k, input string tag);
    int k = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) begin
        k = i;
        break;
      end
    end
    chk({tag, "_latency"}, k, exp_k);
    @(negedge clk);
    chk({tag, "_done_width"}, {31'b0, done}, 32'd0);
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    chk({tag, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1 [4];
    logic [7:0] t2 [7];
    int base;
    t1 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    t2 = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    src = '0; dst = '0; len = '0; pattern = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;

    // start asserted together with reset must be ignored
    start = 1'b1; len = 8'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'b0, mem_wdata}, 32'd0);
    start = 1'b0; len = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // forward copy
    for (int i = 0; i < 4; i++) bd_write(8'h10 + 8'(i), t1[i]);
    for (int i = 0; i < 4; i++) bd_write(8'h40 + 8'(i), 8'h00);
    start_cmd(1'b0, 8'h10, 8'h40, 8'd4, 8'h00, 99);
    wait_done(8, "t1");
    chk("t1_en_count", en_cnt - en_mark, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_dst", {24'b0, mem[8'h40 + 8'(i)]}, {24'b0, t1[i]});
      chk("t1_src_kept", {24'b0, mem[8'h10 + 8'(i)]}, {24'b0, t1[i]});
    end

    // overlapping copy runs backward
    for (int i = 0; i < 5; i++) bd_write(8'h20 + 8'(i), 8'(i + 1));
    bd_write(8'h25, 8'hEE);
    bd_write(8'h26, 8'hEE);
    start_cmd(1'b0, 8'h20, 8'h22, 8'd5, 8'h00, 99);
    wait_done(10, "t2");
    chk("t2_first_write", {24'b0, first_wr}, 32'h26);
    for (int i = 0; i < 7; i++) chk("t2_mem", {24'b0, mem[8'h20 + 8'(i)]}, {24'b0, t2[i]});

    // fill across the top of the address space
    bd_write(8'hFE, 8'h00); bd_write(8'hFF, 8'h00);
    bd_write(8'h00, 8'h00); bd_write(8'h01, 8'h00);
    bd_write(8'h02, 8'h33);
    start_cmd(1'b1, 8'h00, 8'hFE, 8'd4, 8'h5A, 99);
    wait_done(4, "t3");
    chk("t3_fe", {24'b0, mem[8'hFE]}, 32'h5A);
    chk("t3_ff", {24'b0, mem[8'hFF]}, 32'h5A);
    chk("t3_00", {24'b0, mem[8'h00]}, 32'h5A);
    chk("t3_01", {24'b0, mem[8'h01]}, 32'h5A);
    chk("t3_02_untouched", {24'b0, mem[8'h02]}, 32'h33);

    // zero-length command issued in the cycle right after the previous done
    base = busy_cnt;
    start_cmd(1'b0, 8'h30, 8'h50, 8'd0, 8'h00, 99);
    wait_done(0, "t4");
    chk("t4_no_write", en_cnt - en_mark, 32'd0);
    chk("t4_no_busy", busy_cnt - base, 32'd0);

    // start while busy is ignored
    for (int i = 0; i < 3; i++) bd_write(8'h60 + 8'(i), 8'h00);
    start_cmd(1'b0, 8'h10, 8'h60, 8'd3, 8'h00, 99);
    mode = 1'b1; src = 8'h00; dst = 8'h10; len = 8'd2; pattern = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(5, "t5a");
    chk("t5a_en_count", en_cnt - en_mark, 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t5a_dst", {24'b0, mem[8'h60 + 8'(i)]}, {24'b0, t1[i]});
      chk("t5a_src_kept", {24'b0, mem[8'h10 + 8'(i)]}, {24'b0, t1[i]});
    end

    // reset during the third WRITE of an 8-word copy
    for (int i = 0; i < 4; i++) bd_write(8'h14 + 8'(i), 8'h15 + 8'(i));
    for (int i = 0; i < 8; i++) bd_write(8'h70 + 8'(i), 8'h00);
    base = done_cnt;
    start_cmd(1'b0, 8'h10, 8'h70, 8'd8, 8'h00, 2);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t5b_en_gated", {31'b0, mem_en}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5b_idle_busy", {31'b0, busy}, 32'd0);
    chk("t5b_idle_done", {31'b0, done}, 32'd0);
    chk("t5b_idle_en", {31'b0, mem_en}, 32'd0);
    chk("t5b_idle_addr", {24'b0, mem_addr}, 32'd0);
    repeat (4) @(negedge clk);
    chk("t5b_no_done", done_cnt - base, 32'd0);
    chk("t5b_en_count", en_cnt - en_mark, 32'd2);
    chk("t5b_sb_empty", exp_q.size(), 32'd0);
    chk("t5b_w0", {24'b0, mem[8'h70]}, 32'hA1);
    chk("t5b_w1", {24'b0, mem[8'h71]}, 32'hB2);
    chk("t5b_w2_blocked", {24'b0, mem[8'h72]}, 32'h00);

    // next command after the aborted one
    @(posedge clk); #1;
    start_cmd(1'b1, 8'h00, 8'h72, 8'd2, 8'h77, 99);
    wait_done(2, "t5c");
    chk("t5c_72", {24'b0, mem[8'h72]}, 32'h77);
    chk("t5c_73", {24'b0, mem[8'h73]}, 32'h77);
    chk("t5c_74_untouched", {24'b0, mem[8'h74]}, 32'h00);

    // back-to-back copy in the cycle after done
    start_cmd(1'b0, 8'h70, 8'h90, 8'd1, 8'h00, 99);
    wait_done(2, "t6");
    chk("t6_dst", {24'b0, mem[8'h90]}, 32'hA1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
